alu_seq_exec: RTL

ALU_SEQ_EXEC -- requirements
Module: alu_seq_exec

---
 rtl/alu_seq_exec.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle integer/branch ops plus an iterative shift-add multiplier.
// Optional MULHU (unsigned high multiply) is enabled by defining MULHU_EN.
module alu_seq_exec #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned MUL_STEP_BITS = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            illegal
);

  localparam int unsigned N_STEPS = XLEN / MUL_STEP_BITS;
  localparam int unsigned CNT_W   = $clog2(N_STEPS) + 1;
  localparam int unsigned SH_W    = $clog2(XLEN);
  localparam int unsigned ACC_W   = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [XLEN-1:0]   r_result;
  logic              r_taken;
  logic              r_illegal;
  logic [ACC_W-1:0]  r_acc;
  logic [ACC_W-1:0]  r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mul_hi;
  logic              r_mul_signed;

  logic              w_is_mul;
  logic              w_mul_hi;
  logic              w_mul_signed;
  logic              w_illegal;
  logic              w_taken;
  logic [XLEN-1:0]   w_alu;
  logic [SH_W-1:0]   w_shamt;
  logic [ACC_W-1:0]  w_acc_nxt;
  logic              w_last;
  logic              w_unused;

  assign w_shamt  = src_b[SH_W-1:0];
  assign w_last   = (r_cnt == CNT_W'(N_STEPS - 1));
  assign w_unused = ^{op[3:0], funct7[6:1]};

  // Instruction decode and single-cycle results, taken straight from the request inputs
  always_comb begin
    w_is_mul     = 1'b0;
    w_mul_hi     = 1'b0;
    w_mul_signed = 1'b1;
    w_illegal    = 1'b0;
    w_taken      = 1'b0;
    w_alu        = '0;
    if (op[6]) begin
      case (funct3)
        3'b000:  w_taken = (src_a == src_b);
        3'b001:  w_taken = (src_a != src_b);
        3'b100:  w_taken = ($signed(src_a) <  $signed(src_b));
        3'b101:  w_taken = ($signed(src_a) >= $signed(src_b));
        default: w_illegal = 1'b1;
      endcase
      w_alu = XLEN'(w_taken);
    end else if (op[5:4] == 2'b11) begin
      if (!funct7[0]) begin
        case (funct3)
          3'b000:  w_alu = src_a + src_b;
          3'b001:  w_alu = src_a << w_shamt;
          3'b100:  w_alu = src_a ^ src_b;
          3'b101:  w_alu = $unsigned($signed(src_a) >>> w_shamt);
          3'b110:  w_alu = src_a | src_b;
          3'b111:  w_alu = src_a & src_b;
          default: w_illegal = 1'b1;
        endcase
      end else begin
        case (funct3)
          3'b000: w_is_mul = 1'b1;
          3'b001: begin
            w_is_mul = 1'b1;
            w_mul_hi = 1'b1;
          end
`ifdef MULHU_EN
          3'b011: begin
            w_is_mul     = 1'b1;
            w_mul_hi     = 1'b1;
            w_mul_signed = 1'b0;
          end
`endif
          default: w_illegal = 1'b1;
        endcase
      end
    end else if (funct3 == 3'b100) begin
      w_alu = src_a ^ src_b;
    end else begin
      w_alu = src_a + src_b;
    end
    if (w_illegal) begin
      w_alu   = '0;
      w_taken = 1'b0;
    end
  end

  // One multiply step; the top multiplier bit carries negative weight for signed operands
  always_comb begin
    w_acc_nxt = r_acc;
    for (int j = 0; j < int'(MUL_STEP_BITS); j++) begin
      if (r_mplier[j]) begin
        if (r_mul_signed && w_last && (j == int'(MUL_STEP_BITS) - 1))
          w_acc_nxt = w_acc_nxt - (r_mcand << j);
        else
          w_acc_nxt = w_acc_nxt + (r_mcand << j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_nxt = w_is_mul ? S_MUL : S_DONE;
      S_MUL:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // Operand capture at acceptance and multiplier iteration
  always_ff @(posedge clk) begin
    if (reset) begin
      r_result     <= '0;
      r_taken      <= 1'b0;
      r_illegal    <= 1'b0;
      r_acc        <= '0;
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_cnt        <= '0;
      r_mul_hi     <= 1'b0;
      r_mul_signed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_result     <= w_alu;
            r_taken      <= w_taken;
            r_illegal    <= w_illegal;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_mcand      <= {{XLEN{w_mul_signed & src_a[XLEN-1]}}, src_a};
            r_mplier     <= src_b;
            r_mul_hi     <= w_mul_hi;
            r_mul_signed <= w_mul_signed;
          end
        end
        S_MUL: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << MUL_STEP_BITS;
          r_mplier <= r_mplier >> MUL_STEP_BITS;
          r_cnt    <= r_cnt + CNT_W'(1);
          if (w_last)
            r_result <= r_mul_hi ? w_acc_nxt[ACC_W-1:XLEN] : w_acc_nxt[XLEN-1:0];
        end
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign branch_taken = r_taken;
  assign illegal      = r_illegal;

endmodule
